// File: rtl/pixfetch_pkg.sv
// Shared types and widths for the pixel fetch scheduler.
// The memory-side widths are fixed by the external pixel memory: 12-bit linear index, 8 pixels per word.
package pixfetch_pkg;

  localparam int LINEAR_W = 12;
  localparam int ADDR_W   = 9;
  localparam int PIX_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/pixfetch_tag_pipe.sv
// Shift register of {valid, x} tags that tracks fetch reads through the memory latency.
// A flush drops every tag in flight, so none of them can ever reach write-back.
module pixfetch_tag_pipe #(
  parameter int RD_LAT = 2,
  parameter int X_W    = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  input  logic [X_W-1:0] in_x,
  output logic           out_valid,
  output logic [X_W-1:0] out_x,
  output logic           pending
);

  logic           valid_q [RD_LAT];
  logic [X_W-1:0] x_q     [RD_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        valid_q[i] <= 1'b0;
        x_q[i]     <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < RD_LAT; i++) begin
        valid_q[i] <= 1'b0;
        x_q[i]     <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      x_q[0]     <= in_x;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        x_q[i]     <= x_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_x     = x_q[RD_LAT-1];

  // Tags still in flight behind the output stage; the output stage itself is written this cycle.
  // NOTE: always_comb outputs get a default first so no path can leave them unassigned and infer a latch.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pending = pending | valid_q[i];
    end
  end

endmodule

// File: rtl/pixel_fetch_scheduler.sv
// Streams one scanline of 4-bit pixels from external memory into a ping-pong line buffer,
// while the video path reads the previously fetched line from the front buffer.
module pixel_fetch_scheduler
  import pixfetch_pkg::*;
#(
  parameter int H_PIX   = 64,
  parameter int V_LINES = 64,
  parameter int RD_LAT  = 2,
  parameter int LINE_W  = $clog2(V_LINES),
  parameter int X_W     = $clog2(H_PIX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_req,
  input  logic [LINE_W-1:0] line_num,
  input  logic              frame_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_pix_sel,
  output logic              mem_bank,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic [X_W-1:0]    rd_x,
  output logic [PIX_W-1:0]  rd_pix,
  output logic              busy,
  output logic              underrun
);

  fetch_state_t      state;
  logic [X_W:0]      x_issue;
  logic [LINE_W-1:0] line_q;
  logic              front_sel;
  logic              issue_v;
  logic [X_W-1:0]    issue_x;

  logic              flush;
  logic              tag_valid;
  logic [X_W-1:0]    tag_x;
  logic              tag_pending;
  logic              wr_en;

  logic [LINE_W-1:0] idx_line;
  logic [X_W:0]      idx_x;
  logic [LINEAR_W-1:0] issue_idx;

  logic [PIX_W-1:0]  line_buf [2][H_PIX];

  function automatic logic [LINEAR_W-1:0] linear_idx(input logic [LINE_W-1:0] line,
                                                     input logic [X_W:0]      x);
    return LINEAR_W'(line) * LINEAR_W'(H_PIX) + LINEAR_W'(x);
  endfunction

  // A request issues x=0 on its own edge so the first address is on the pins the very next cycle.
  always_comb begin
    idx_line  = line_req ? line_num : line_q;
    idx_x     = line_req ? '0 : x_issue;
    issue_idx = linear_idx(idx_line, idx_x);
  end

  assign flush = line_req && (state != IDLE);
  assign wr_en = tag_valid && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      x_issue     <= '0;
      line_q      <= '0;
      front_sel   <= 1'b0;
      issue_v     <= 1'b0;
      issue_x     <= '0;
      mem_addr    <= '0;
      mem_pix_sel <= '0;
      mem_bank    <= 1'b0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
    end else if (line_req) begin
      if (state != IDLE) underrun <= 1'b1;
      front_sel   <= ~front_sel;
      line_q      <= line_num;
      mem_bank    <= frame_bank;
      mem_addr    <= issue_idx[LINEAR_W-1:3];
      mem_pix_sel <= issue_idx[2:0];
      issue_v     <= 1'b1;
      issue_x     <= '0;
      x_issue     <= (X_W+1)'(1);
      state       <= FETCH;
      busy        <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          mem_addr    <= issue_idx[LINEAR_W-1:3];
          mem_pix_sel <= issue_idx[2:0];
          issue_v     <= 1'b1;
          issue_x     <= X_W'(x_issue);
          x_issue     <= x_issue + 1'b1;
          if (x_issue == (X_W+1)'(H_PIX - 1)) state <= DRAIN;
        end
        DRAIN: begin
          issue_v <= 1'b0;
          if (!issue_v && !tag_pending) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: issue_v <= 1'b0;
      endcase
    end
  end

  // The tag enters the pipe alongside the address on the pins, so its output lines up with pixel_in.
  pixfetch_tag_pipe #(
    .RD_LAT (RD_LAT),
    .X_W    (X_W)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (issue_v),
    .in_x      (issue_x),
    .out_valid (tag_valid),
    .out_x     (tag_x),
    .pending   (tag_pending)
  );

  // NOTE: the line buffers are reset explicitly because a partially fetched line is displayed as-is after an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int x = 0; x < H_PIX; x++) begin
          line_buf[b][x] <= '0;
        end
      end
      rd_pix <= '0;
    end else begin
      if (wr_en) line_buf[~front_sel][tag_x] <= pixel_in;
      rd_pix <= line_buf[front_sel][rd_x];
    end
  end

endmodule

// File: doc/pixel_fetch_scheduler.md
Name: pixel_fetch_scheduler

Overview:
- Sequences the external pixel-memory interface (mem_addr/mem_bank/mem_pix_sel out, 4-bit pixel_in back) for the video generator.
- On each line request, streams one scanline of 4-bit pixels from external memory into a ping-pong line buffer.
- The video path reads the previously fetched line with 1-cycle latency.
- Sits in the clk_video domain between the top-level I/O pins and the video generator.

Parameters:
- H_PIX, 64, pixels per line (power of 2, 8..64).
- V_LINES, 64, lines per frame; H_PIX*V_LINES must be <= 4096 (one bank).
- RD_LAT, 2, cycles from address driven to pixel_in valid (1..4).

Ports:
- clk  in  1  video pixel clock.
- reset  in  1  asynchronous, active-high.
- line_req  in  1  single-cycle pulse: swap buffers and start fetching line_num.
- line_num  in  $clog2(V_LINES)  line to fetch into the new back buffer; sampled on line_req.
- frame_bank  in  1  memory bank to read; sampled on line_req.
- mem_addr  out  9  word address = linear_idx[11:3], linear_idx = line_num*H_PIX + x.
- mem_pix_sel  out  3  pixel within word = linear_idx[2:0].
- mem_bank  out  1  latched frame_bank.
- pixel_in  in  4  memory read data, valid RD_LAT cycles after the address.
- rd_x  in  $clog2(H_PIX)  display read index.
- rd_pix  out  4  front_buf[rd_x], registered.
- busy  out  1  high while in FETCH or DRAIN.
- underrun  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values: mem_addr=0, mem_pix_sel=0, mem_bank=0, rd_pix=0, busy=0, underrun=0, FSM=IDLE, front_sel=0, both buffers=0, valid pipe cleared.
- Reset is asynchronous and takes effect mid-fetch with no completion of outstanding reads.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE + line_req -> FETCH. Toggle front_sel, latch line_num and frame_bank, set x_issue=0.
  - FETCH: each cycle drive address for x_issue, push (valid=1, x_issue) into an RD_LAT-deep tag pipe, then x_issue++. After issuing x=H_PIX-1 -> DRAIN.
  - DRAIN: wait until the tag pipe is empty, then -> IDLE.
- Write-back: when the tag-pipe output is valid, back_buf[tag_x] <= pixel_in, where back_buf = buffer !front_sel.
- Timing: first address is driven on the cycle after line_req. A full line takes H_PIX + RD_LAT cycles from line_req to busy=0. busy deasserts on the cycle after the last write.
- mem_addr/mem_pix_sel hold their last value outside FETCH.
- line_req while busy (overrun):
  - Set underrun.
  - Flush the tag pipe in the same cycle; in-flight returns of the aborted fetch must never be written.
  - Swap and restart FETCH for the new line_num.
  - The buffer now in front holds a partially fetched line; it is displayed as-is.
- line_req while IDLE: no flag, clean swap.
- x_issue and linear_idx are computed at full width with no truncation. The H_PIX*V_LINES<=4096 bound guarantees linear_idx fits 12 bits.
- rd_pix reads the front buffer only; one-cycle latency from rd_x. On the swap cycle the new front takes effect for reads registered on the following cycle.
- Reads and writes always target opposite buffers, so there is no read/write collision.

Decomposition:
- Package pixfetch_pkg: fetch_state_t enum (IDLE, FETCH, DRAIN), LINEAR_W=12, ADDR_W=9, PIX_W=4.
- One sub-module: pixfetch_tag_pipe. An RD_LAT-deep shift register of {valid, x}, with a synchronous flush and asynchronous reset.

Test Plan:
- Reset then line_req with line_num=0, frame_bank=0, memory model returning pixel = x[3:0], RD_LAT=2:
  - mem_addr 0..7 with pix_sel 0..7 cycling over 64 cycles.
  - busy high for exactly 66 cycles.
  - After a second line_req, rd_x=5 gives rd_pix=5 one cycle later.
- line_num=3, frame_bank=1: first address 24 (idx 192), pix_sel=0, mem_bank=1; last address 31, pix_sel=7.
- Second line_req 30 cycles into a fetch:
  - underrun=1.
  - No writes from the 2 in-flight tags.
  - New fetch completes in 66 cycles.
  - underrun stays 1 until reset.
- Back-to-back clean lines A/B with distinct data: rd_pix always shows the previous line while the back buffer fills; no corruption on the swap cycle.
- Assert reset mid-FETCH: outputs go to reset values immediately (asynchronously); a subsequent line_req fetches cleanly.
- RD_LAT=4 sweep: data aligned to the correct x; busy width = H_PIX+4.
